// File: rtl/nibble_serial_adder.sv
// Multi-precision serial adder: adds two NIBBLES x 4-bit operands one nibble per clock
// through a single 4-bit slice adder, with valid/ready handshakes on input and result.
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   cout,
    output logic                   overflow,
    output logic                   busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Returns {c3, c4, s[3:0]}: c3 is the carry into bit 3, c4 the slice carry-out.
    function automatic logic [5:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                             input logic c);
        logic [3:0] low;
        logic [4:0] full;
        low  = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b000, c};
        full = {1'b0, x} + {1'b0, y} + {4'b0000, c};
        return {low[3], full};
    endfunction

    state_t          state_q, state_d;
    logic [W-1:0]    a_sh_q, a_sh_d;
    logic [W-1:0]    b_sh_q, b_sh_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;

    logic [5:0]      slice_s;
    logic [W-1:0]    acc_shift_s;
    logic            last_s;

    // Slice datapath: one 4-bit add per cycle, result nibble enters the accumulator at the top.
    always_comb begin
        slice_s     = slice_add(a_sh_q[3:0], b_sh_q[3:0], carry_q);
        acc_shift_s = (acc_q >> 4) | (W'(slice_s[3:0]) << (W - 4));
        last_s      = (cnt_q == CW'(NIBBLES - 1));
    end

    // Next-state and register-update logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = {CW{1'b0}};
                    acc_d   = {W{1'b0}};
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                acc_d   = acc_shift_s;
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = slice_s[4];
                cnt_d   = cnt_q + CW'(1);
                if (last_s) begin
                    sum_d   = acc_shift_s;
                    cout_d  = slice_s[4];
                    ovf_d   = slice_s[5] ^ slice_s[4];
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sh_q  <= {W{1'b0}};
            b_sh_q  <= {W{1'b0}};
            acc_q   <= {W{1'b0}};
            sum_q   <= {W{1'b0}};
            carry_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake flags decode from state only; in_ready is also held low during reset.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder: a 4-nibble and a 1-nibble instance, directed vectors.
module tb_nibble_serial_adder;

    typedef struct {
        logic [15:0] s;
        logic        c;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, cin, out_valid, out_ready, cout, overflow, busy;
    logic [15:0] a, b, sum;

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, overflow1, busy1;
    logic [3:0]  a1, b1, sum1;

    exp_t q4[$];
    exp_t q1[$];
    int   tests = 0;
    int   fails = 0;
    int   lat;

    nibble_serial_adder #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .overflow(overflow1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Scoreboard monitor, 4-nibble instance: compare on each result handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL n4 unexpected result: sum 0x%0h with no pending expectation", sum);
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("n4 sum", {16'd0, sum}, {16'd0, e.s});
                check("n4 cout", {31'd0, cout}, {31'd0, e.c});
                check("n4 overflow", {31'd0, overflow}, {31'd0, e.o});
            end
        end
    end

    // Scoreboard monitor, 1-nibble instance.
    always @(negedge clk) begin
        if (!rst && out_valid1 && out_ready1) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL n1 unexpected result: sum 0x%0h with no pending expectation", sum1);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("n1 sum", {28'd0, sum1}, {16'd0, e.s});
                check("n1 cout", {31'd0, cout1}, {31'd0, e.c});
                check("n1 overflow", {31'd0, overflow1}, {31'd0, e.o});
            end
        end
    end

    // Accept one operand set on the 4-nibble instance and wait (bounded) for out_valid.
    task automatic send4(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic [15:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        check("n4 in_ready before accept", {31'd0, in_ready}, 32'd1);
        e.s = es;
        e.c = ec;
        e.o = eo;
        q4.push_back(e);
        a        = av;
        b        = bv;
        cin      = cv;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("n4 busy after accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        check("n4 latency", n, 32'd4);
    endtask

    // Complete a pending result with out_ready high; out_valid must last one cycle.
    task automatic finish4();
        out_ready = 1'b1;
        step();
        check("n4 out_valid one cycle", {31'd0, out_valid}, 32'd0);
        check("n4 in_ready after handshake", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send1(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                         input logic [3:0] es, input logic ec, input logic eo);
        exp_t e;
        int   n;
        check("n1 in_ready before accept", {31'd0, in_ready1}, 32'd1);
        e.s = {12'd0, es};
        e.c = ec;
        e.o = eo;
        q1.push_back(e);
        a1        = av;
        b1        = bv;
        cin1      = cv;
        in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin
            step();
            n++;
        end
        check("n1 latency", n, 32'd1);
        step();
        check("n1 out_valid one cycle", {31'd0, out_valid1}, 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        a          = 16'd0;
        b          = 16'd0;
        cin        = 1'b0;
        out_ready  = 1'b1;
        in_valid1  = 1'b0;
        a1         = 4'd0;
        b1         = 4'd0;
        cin1       = 1'b0;
        out_ready1 = 1'b1;

        // Reset state
        repeat (3) step();
        check("reset in_ready", {31'd0, in_ready}, 32'd0);
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset sum", {16'd0, sum}, 32'd0);
        check("reset cout", {31'd0, cout}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        step();
        check("in_ready after reset", {31'd0, in_ready}, 32'd1);

        // Basic additions
        send4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        finish4();
        send4(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        finish4();
        send4(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        finish4();
        send4(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        finish4();
        send4(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        finish4();

        // Backpressure: result held while out_ready is low, new operands ignored
        out_ready = 1'b0;
        send4(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        a        = 16'h1111;
        b        = 16'h2222;
        cin      = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            step();
            check("bp out_valid held", {31'd0, out_valid}, 32'd1);
            check("bp sum held", {16'd0, sum}, 32'h5555);
            check("bp busy held", {31'd0, busy}, 32'd1);
            check("bp in_ready low", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        step();
        check("bp out_valid after handshake", {31'd0, out_valid}, 32'd0);
        check("bp busy after handshake", {31'd0, busy}, 32'd0);
        send4(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0);
        finish4();

        // Reset in the middle of RUN: operation abandoned, no result
        a        = 16'hFFFF;
        b        = 16'h0001;
        cin      = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst busy", {31'd0, busy}, 32'd0);
        check("midrst sum", {16'd0, sum}, 32'd0);
        check("midrst cout", {31'd0, cout}, 32'd0);
        check("midrst overflow", {31'd0, overflow}, 32'd0);
        check("midrst in_ready gated", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        repeat (3) step();
        check("midrst no result", {31'd0, out_valid}, 32'd0);
        send4(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        finish4();

        // Single-nibble instance
        send1(4'hF, 4'h1, 1'b1, 4'h1, 1'b1, 1'b0);
        send1(4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

        repeat (2) step();
        check("n4 scoreboard drained", q4.size(), 32'd0);
        check("n1 scoreboard drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-precision adder that sums two NIBBLES×4-bit operands one 4-bit slice per clock, carrying each slice's carry-out into the next slice's carry-in. It sits directly upstream of the 4-bit slice adder datapath: it sequences operand nibbles and carry into a combinational 4-bit adder and collects its sum and carry-out. Operands enter through a valid/ready handshake, and the assembled result leaves through another valid/ready handshake.

## Interface
- NIBBLES, 4: number of 4-bit slices; operand width W = 4*NIBBLES; legal range 1..16.

- clk  input  1  rising-edge clock, sole clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set present on a, b, cin.
- in_ready  output  1  block can accept operands.
- a  input  W  operand A.
- b  input  W  operand B.
- cin  input  1  carry into slice 0.
- out_valid  output  1  result present on sum, cout, overflow.
- out_ready  input  1  consumer accepts result.
- sum  output  W  A + B + cin, modulo 2^W.
- cout  output  1  carry out of bit W-1.
- overflow  output  1  two's-complement overflow: carry into bit W-1 XOR carry out of bit W-1.
- busy  output  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state: IDLE.
- IDLE:
  - in_ready = 1 (forced 0 while rst = 1).
  - On in_valid & in_ready at an edge: load a and b into shift registers, load the carry register with cin, clear the slice counter, clear the accumulator, go to RUN.
- RUN, one slice per edge:
  - Compute {c4, s[3:0]} = a_sh[3:0] + b_sh[3:0] + carry.
  - Shift s into the accumulator from the top.
  - Shift a_sh and b_sh right by 4. Set carry to c4.
  - Increment the counter.
  - On the edge that processes slice NIBBLES-1:
    - load sum from the final accumulator value;
    - load cout from c4;
    - load overflow from c3 XOR c4, where c3 is the carry into bit 3 of the final slice;
    - go to DONE.
- DONE:
  - out_valid = 1; sum, cout and overflow hold stable.
  - On out_valid & out_ready at an edge: go to IDLE.
- in_ready = 0 in RUN and DONE. in_valid in those states is ignored, and a/b/cin are not sampled.
- The sum, cout and overflow registers change only on the RUN→DONE edge. They hold the last completed result in IDLE and RUN.
- Arithmetic is unsigned modulo 2^W. The overflow flag is the signed interpretation only; the sum bits are identical either way.
- Reset values: in_ready 0 while rst is high, then 1; out_valid 0; busy 0; sum 0; cout 0; overflow 0. The internal shift registers, counter and carry are also 0.
- Reset mid-operation (RUN or DONE): the operation is abandoned, the FSM goes to IDLE, the outputs return to their reset values, and no out_valid pulse is produced.

## Timing
- Acceptance at edge k. RUN edges k+1..k+NIBBLES process slices 0..NIBBLES-1. out_valid goes high after edge k+NIBBLES.
- Latency is NIBBLES edges from the accept edge to out_valid.
- Result handshake at edge m: out_valid is low and in_ready is high after edge m.
- There is no combinational path from in_valid to in_ready or from out_ready to out_valid. in_ready, out_valid and busy decode from state only; in_ready is additionally gated by rst.
- Minimum spacing between accepts is NIBBLES+2 edges (accept, NIBBLES RUN edges, result handshake).
- out_ready held high in DONE: out_valid lasts exactly one cycle.
- out_ready low: out_valid and the result hold indefinitely.
- NIBBLES = 1: a single RUN edge; the carry chain is the slice itself.
- Carry propagates across slices only through the carry register. The combinational path is one 4-bit slice adder.

## Test plan
- NIBBLES=4, after reset, a=0x1234, b=0x4321, cin=0, out_ready=1 -> sum 0x5555, cout 0, overflow 0; out_valid high exactly 4 edges after the accept edge, for one cycle.
- a=0xFFFF, b=0x0001, cin=0 -> sum 0x0000, cout 1, overflow 0. Then a=0x0000, b=0x0000, cin=1 -> sum 0x0001, cout 0 (cin enters slice 0 only).
- a=0x7FFF, b=0x0001 -> sum 0x8000, cout 0, overflow 1. Then a=0x8000, b=0x8000 -> sum 0x0000, cout 1, overflow 1.
- Backpressure: result 0x5555 pending, out_ready low for 3 cycles, in_valid high with a=0x1111 -> out_valid, sum 0x5555 and busy stay stable, in_ready 0, new operands not taken. After the out_ready handshake, in_ready is 1 on the next cycle and 0x1111+b is accepted afterwards.
- Reset mid-RUN after 2 slices of 0xFFFF+0x0001 -> out_valid never asserts; sum, cout and overflow are 0 and busy is 0 after the reset edge. A subsequent 0x0F0F+0x00F1 gives 0x1000, cout 0.
- NIBBLES=1 instance: a=0xF, b=0x1, cin=1 -> sum 0x1, cout 1, overflow 0, 1-edge latency. Then a=0x7, b=0x1, cin=0 -> sum 0x8, overflow 1.
